// File: rtl/paddle_ctrl_pkg.sv
// Shared Pong definitions: playfield defaults, paddle direction/state
// encoding and the button-pair direction decode.
package paddle_ctrl_pkg;

   localparam int unsigned SCREEN_H_DEF = 480;
   localparam int unsigned PADDLE_H_DEF = 64;
   localparam int unsigned Y_MAX_DEF    = SCREEN_H_DEF - PADDLE_H_DEF;
   localparam int unsigned Y_INIT_DEF   = (SCREEN_H_DEF - PADDLE_H_DEF) / 2;

   // Motion state; the encoding matches the original header values.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_UP   = 2'b01,
      ST_DN   = 2'b10
   } dir_e;

   // Pressing both buttons together means no motion.
   function automatic dir_e decode_dir(input logic up, input logic dn);
      dir_e d;
      case ({up, dn})
         2'b10:   d = ST_UP;
         2'b01:   d = ST_DN;
         default: d = ST_IDLE;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/paddle_ctrl_sat_step.sv
// sat_step: combinational saturating add/subtract of a step, clamped to
// [0, y_max_i]. Computed one bit wider so nothing wraps.
module sat_step
   import paddle_ctrl_pkg::*;
#(
   parameter int unsigned Y_W = 10
) (
   input  logic [Y_W-1:0] y_i,
   input  logic [Y_W-1:0] step_i,
   input  logic [Y_W-1:0] y_max_i,
   input  dir_e           dir_i,
   output logic [Y_W-1:0] y_o
);

   logic [Y_W:0] y_wide;
   logic [Y_W:0] step_wide;
   logic [Y_W:0] sum_wide;

   // Clamp the moved position to the visible range.
   always_comb begin
      y_wide    = {1'b0, y_i};
      step_wide = {1'b0, step_i};
      sum_wide  = y_wide + step_wide;
      y_o       = y_i;
      case (dir_i)
         ST_UP: begin
            if (y_wide < step_wide) y_o = '0;
            else                    y_o = y_i - step_i;
         end
         ST_DN: begin
            if (sum_wide > {1'b0, y_max_i}) y_o = y_max_i;
            else                            y_o = sum_wide[Y_W-1:0];
         end
         default: y_o = y_i;
      endcase
   end

endmodule

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: per-player paddle position. Moves once per frame_tick
// according to the debounced button pair, clamped to [0, Y_MAX].
// Build option: define PADDLE_ACCEL_EN to switch to STEP_FAST after a
// hold of RAMP_FRAMES+1 consecutive moves in one direction.
module paddle_ctrl
   import paddle_ctrl_pkg::*;
#(
   parameter int unsigned SCREEN_H    = SCREEN_H_DEF,
   parameter int unsigned PADDLE_H    = PADDLE_H_DEF,
   parameter int unsigned Y_W         = 10,
   parameter int unsigned Y_INIT      = Y_INIT_DEF,
   parameter int unsigned STEP_SLOW   = 2,
   parameter int unsigned STEP_FAST   = 6,
   parameter int unsigned RAMP_FRAMES = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           db_up,
   input  logic           db_dn,
   input  logic           frame_tick,
   input  logic           center,
   output logic [Y_W-1:0] paddle_y,
   output logic           moving,
   output logic           at_top,
   output logic           at_bot
);

   localparam int unsigned    Y_MAX    = SCREEN_H - PADDLE_H;
   localparam logic [Y_W-1:0] Y_MAX_V  = Y_W'(Y_MAX);
   localparam logic [Y_W-1:0] Y_INIT_V = Y_W'(Y_INIT);
   localparam logic [Y_W-1:0] SLOW_V   = Y_W'(STEP_SLOW);

   // Reject configurations where the fast step or ramp make no sense.
   if (STEP_FAST < STEP_SLOW || RAMP_FRAMES == 0 || Y_INIT > Y_MAX) begin : g_bad_cfg
      $error("paddle_ctrl: inconsistent step/ramp/init parameters");
   end

   dir_e           state_q;
   logic [Y_W-1:0] y_q;
   logic           moving_q;
   dir_e           dir_d;
   logic [Y_W-1:0] step_d;
   logic [Y_W-1:0] y_d;

   assign dir_d = decode_dir(db_up, db_dn);

`ifdef PADDLE_ACCEL_EN
   localparam int unsigned       HOLD_W = $clog2(RAMP_FRAMES + 1);
   localparam logic [HOLD_W-1:0] RAMP_V = HOLD_W'(RAMP_FRAMES);
   localparam logic [Y_W-1:0]    FAST_V = Y_W'(STEP_FAST);

   logic [HOLD_W-1:0] hold_q;

   // Fast step only while continuing an already saturated hold.
   always_comb begin
      step_d = SLOW_V;
      if (dir_d == state_q && hold_q == RAMP_V) step_d = FAST_V;
   end

   // Hold counter: cleared on any direction change, saturates at RAMP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q <= '0;
      end else if (center) begin
         hold_q <= '0;
      end else if (frame_tick) begin
         if (dir_d != state_q)                         hold_q <= '0;
         else if (state_q != ST_IDLE && hold_q != RAMP_V) hold_q <= hold_q + HOLD_W'(1);
      end
   end
`else
   assign step_d = SLOW_V;
`endif

   sat_step #(
      .Y_W (Y_W)
   ) u_sat_step (
      .y_i     (y_q),
      .step_i  (step_d),
      .y_max_i (Y_MAX_V),
      .dir_i   (dir_d),
      .y_o     (y_d)
   );

   // Motion FSM with registered position and moving flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         y_q      <= Y_INIT_V;
         moving_q <= 1'b0;
      end else if (center) begin
         state_q  <= ST_IDLE;
         y_q      <= Y_INIT_V;
         moving_q <= 1'b0;
      end else if (frame_tick) begin
         if (dir_d != state_q) begin
            state_q  <= dir_d;
            y_q      <= y_d;
            moving_q <= (dir_d != ST_IDLE);
         end else if (state_q != ST_IDLE) begin
            y_q      <= y_d;
         end
      end
   end

   assign paddle_y = y_q;
   assign moving   = moving_q;
   assign at_top   = (y_q == '0);
   assign at_bot   = (y_q == Y_MAX_V);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Self-checking bench for paddle_ctrl: directed scenarios plus a random
// run against a run-length behavioural model of paddle motion.
module tb_paddle_ctrl;

   localparam int Y_INIT = 208;
   localparam int Y_MAX  = 416;
   localparam int SLOW   = 2;
   localparam int FAST   = 6;
   localparam int RAMP   = 16;
`ifdef PADDLE_ACCEL_EN
   localparam bit ACCEL = 1'b1;
`else
   localparam bit ACCEL = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       db_up = 1'b0, db_dn = 1'b0, frame_tick = 1'b0, center = 1'b0;
   logic [9:0] paddle_y;
   logic       moving, at_top, at_bot;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: position, current direction (-1/0/+1), consecutive-move count.
   int m_y, m_dir, m_run;

   paddle_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .db_up      (db_up),
      .db_dn      (db_dn),
      .frame_tick (frame_tick),
      .center     (center),
      .paddle_y   (paddle_y),
      .moving     (moving),
      .at_top     (at_top),
      .at_bot     (at_bot)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_y = Y_INIT; m_dir = 0; m_run = 0;
   endtask

   task automatic model_tick(input bit up, input bit dn, input bit c);
      int d, step;
      if (c) begin
         model_reset();
         return;
      end
      d = (up && !dn) ? -1 : (dn && !up) ? 1 : 0;
      if (d == 0) begin
         m_dir = 0; m_run = 0;
      end else begin
         if (d == m_dir) m_run++;
         else begin m_dir = d; m_run = 1; end
         step = (ACCEL && m_run >= RAMP + 2) ? FAST : SLOW;
         m_y = m_y + d * step;
         if (m_y < 0) m_y = 0;
         if (m_y > Y_MAX) m_y = Y_MAX;
      end
   endtask

   // One frame tick with the given button levels; outputs settle #1 later.
   task automatic tick(input bit up, input bit dn, input bit c);
      @(negedge clk);
      db_up = up; db_dn = dn; center = c; frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0; center = 1'b0;
      model_tick(up, dn, c);
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(negedge clk);
         db_up = 1'($urandom); db_dn = 1'($urandom);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
      n_checks++; if (paddle_y !== 10'd208) begin n_fail++; $display("FAIL reset_y: got %0d expected 208", paddle_y); end
      n_checks++; if (moving !== 1'b0) begin n_fail++; $display("FAIL reset_moving: got %b expected 0", moving); end
      repeat (10) tick(1'b0, 1'b0, 1'b0);
      n_checks++; if (paddle_y !== 10'd208) begin n_fail++; $display("FAIL idle_y: got %0d expected 208", paddle_y); end
      n_checks++; if ({moving, at_top, at_bot} !== 3'b000) begin n_fail++; $display("FAIL idle_flags: got %b expected 000", {moving, at_top, at_bot}); end
   endtask

   task automatic test_hold_down();
      tick(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, 1'b1, 1'b0);
         n_checks++; if (moving !== 1'b1) begin n_fail++; $display("FAIL hold_moving: tick %0d got %b expected 1", i + 1, moving); end
      end
      n_checks++; if (paddle_y !== 10'd218) begin n_fail++; $display("FAIL hold_y: got %0d expected 218", paddle_y); end
   endtask

   task automatic test_accel();
      int exp_final;
      exp_final = ACCEL ? 260 : 248;
      tick(1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 20; i++) begin
         tick(1'b0, 1'b1, 1'b0);
         if (i == 17) begin
            n_checks++; if (paddle_y !== 10'd242) begin n_fail++; $display("FAIL accel_t17: got %0d expected 242", paddle_y); end
         end
      end
      n_checks++; if (int'(paddle_y) !== exp_final) begin n_fail++; $display("FAIL accel_t20: got %0d expected %0d", paddle_y, exp_final); end
   endtask

   task automatic test_clamp_top();
      int budget;
      budget = 0;
      tick(1'b0, 1'b0, 1'b1);
      while (paddle_y != 0 && budget < 200) begin
         tick(1'b1, 1'b0, 1'b0);
         budget++;
         n_checks++; if (int'(paddle_y) !== m_y) begin n_fail++; $display("FAIL top_path: got %0d expected %0d", paddle_y, m_y); end
      end
      n_checks++; if (budget >= 200) begin n_fail++; $display("FAIL top_timeout: got %0d ticks expected <200", budget); end
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, 1'b0, 1'b0);
         n_checks++; if ({paddle_y, at_top, at_bot} !== {10'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL top_hold: got y=%0d top=%b bot=%b expected y=0 top=1 bot=0", paddle_y, at_top, at_bot); end
      end
   endtask

   task automatic test_clamp_bot();
      int budget;
      budget = 0;
      while (paddle_y != 10'd416 && budget < 300) begin
         tick(1'b0, 1'b1, 1'b0);
         budget++;
      end
      n_checks++; if (budget >= 300) begin n_fail++; $display("FAIL bot_timeout: got %0d ticks expected <300", budget); end
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 1'b1, 1'b0);
         n_checks++; if ({paddle_y, at_top, at_bot} !== {10'd416, 1'b0, 1'b1}) begin n_fail++; $display("FAIL bot_hold: got y=%0d top=%b bot=%b expected y=416 top=0 bot=1", paddle_y, at_top, at_bot); end
      end
   endtask

   task automatic test_conflict();
      tick(1'b0, 1'b0, 1'b1);
      repeat (3) tick(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, 1'b1, 1'b0);
         n_checks++; if ({paddle_y, moving} !== {10'd214, 1'b0}) begin n_fail++; $display("FAIL conflict: got y=%0d mv=%b expected y=214 mv=0", paddle_y, moving); end
      end
      tick(1'b1, 1'b0, 1'b0);
      n_checks++; if ({paddle_y, moving} !== {10'd212, 1'b1}) begin n_fail++; $display("FAIL conflict_up: got y=%0d mv=%b expected y=212 mv=1", paddle_y, moving); end
   endtask

   task automatic test_between_ticks();
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b1, 1'b0);
      gap(7);
      n_checks++; if (paddle_y !== 10'd210) begin n_fail++; $display("FAIL gap_hold: got %0d expected 210", paddle_y); end
      tick(1'b0, 1'b1, 1'b0);
      n_checks++; if (paddle_y !== 10'd212) begin n_fail++; $display("FAIL gap_next: got %0d expected 212", paddle_y); end
   endtask

   task automatic test_center();
      int budget;
      budget = 0;
      tick(1'b0, 1'b0, 1'b1);
      while (m_y < 300 && budget < 100) begin tick(1'b0, 1'b1, 1'b0); budget++; end
      tick(1'b0, 1'b1, 1'b1);
      n_checks++; if ({paddle_y, moving} !== {10'd208, 1'b0}) begin n_fail++; $display("FAIL center: got y=%0d mv=%b expected y=208 mv=0", paddle_y, moving); end
   endtask

   task automatic test_async_rst();
      int budget;
      budget = 0;
      while (m_y < 300 && budget < 100) begin tick(1'b0, 1'b1, 1'b0); budget++; end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++; if ({paddle_y, moving} !== {10'd208, 1'b0}) begin n_fail++; $display("FAIL async_rst: got y=%0d mv=%b expected y=208 mv=0", paddle_y, moving); end
      #1 rst = 1'b0;
      model_reset();
   endtask

   task automatic test_random();
      bit up, dn, c;
      up = 1'b0; dn = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 5) == 0) begin up = 1'($urandom); dn = 1'($urandom); end
         c = ($urandom_range(0, 39) == 0);
         tick(up, dn, c);
         n_checks++; if (int'(paddle_y) !== m_y) begin n_fail++; $display("FAIL rnd_y: tick %0d got %0d expected %0d", i, paddle_y, m_y); end
         n_checks++; if (moving !== (m_dir != 0)) begin n_fail++; $display("FAIL rnd_moving: tick %0d got %b expected %b", i, moving, m_dir != 0); end
         n_checks++; if ({at_top, at_bot} !== {m_y == 0, m_y == Y_MAX}) begin n_fail++; $display("FAIL rnd_edges: tick %0d got %b%b expected %b%b", i, at_top, at_bot, m_y == 0, m_y == Y_MAX); end
         gap($urandom_range(0, 3));
      end
   endtask

   initial begin
      test_reset();
      test_hold_down();
      test_accel();
      test_clamp_top();
      test_clamp_bot();
      test_conflict();
      test_between_ticks();
      test_center();
      test_async_rst();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
